led_bargraph_ctrl: RTL and testbench

//   Parametrised distance-to-LED bar-graph driver; successor to the fixed 10-LED threshold bank.

---
 rtl/led_bargraph_ctrl.sv | 160 ++++++++++++++++
 tb/tb_led_bargraph_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/led_bargraph_ctrl.sv
// led_bargraph_ctrl
//   Turns an ultrasonic distance count into a bar-graph level from 0 to NUM_LEDS.
//   The level rises as soon as the distance crosses a step threshold. It falls only
//   once the distance drops HYST counts below that threshold. The LEDs are then
//   driven as a bar or as a single dot.
//
// Optional feature macro: LED_PEAK_HOLD_EN
//   When defined, peak_level holds the highest recent level. It decays by one level
//   every HOLD_CYCLES clocks until it meets the current level. LED[peak-1] is also lit.
//   When undefined, peak_level simply mirrors level.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   dist_counter distance measurement, unsigned, CNT_W bits
//   dist_valid   one-cycle strobe, dist_counter holds a new sample
//   mode         0 = bar, 1 = dot
//   LED          registered LED drive, active-high
//   level        registered quantised level
//   peak_level   registered peak-hold level (mirrors level without the feature)
module led_bargraph_ctrl #(
  parameter int NUM_LEDS    = 10,
  parameter int CNT_W       = 26,
  parameter int STEP        = 14500,
  parameter int HYST        = 500,
  parameter int HOLD_CYCLES = 25000000,
  localparam int LW         = $clog2(NUM_LEDS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CNT_W-1:0]    dist_counter,
  input  logic                dist_valid,
  input  logic                mode,
  output logic [NUM_LEDS-1:0] LED,
  output logic [LW-1:0]       level,
  output logic [LW-1:0]       peak_level
);

  // The extra LW bits keep k*STEP and dist+HYST from wrapping.
  localparam int CW = CNT_W + LW;

  logic [CW-1:0]       dist_ext;
  logic [CW-1:0]       dist_hyst;
  logic [NUM_LEDS-1:0] ge_up;
  logic [NUM_LEDS-1:0] ge_dn;
  logic [LW-1:0]       raw_up;
  logic [LW-1:0]       raw_dn;
  logic [LW-1:0]       level_reg;
  logic [LW-1:0]       level_next;
  logic [LW-1:0]       peak_next;
  logic [NUM_LEDS-1:0] led_reg;
  logic [NUM_LEDS-1:0] led_next;

  assign dist_ext  = {{LW{1'b0}}, dist_counter};
  assign dist_hyst = dist_ext + CW'(HYST);

  // One comparator pair per threshold k = gi+1.
  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_thr
      localparam logic [CW-1:0] THR = CW'(gi + 1) * CW'(STEP);
      assign ge_up[gi] = (dist_ext  >= THR);
      assign ge_dn[gi] = (dist_hyst >= THR);
    end
  endgenerate

  // The thresholds increase with k, so the count of passed compares is the level.
  // The count cannot exceed NUM_LEDS, so the level saturates by construction.
  always_comb begin
    raw_up = '0;
    raw_dn = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      raw_up = raw_up + LW'(ge_up[i]);
      raw_dn = raw_dn + LW'(ge_dn[i]);
    end
  end

  // raw_dn >= raw_up always, so the rise and fall conditions are exclusive.
  always_comb begin
    level_next = level_reg;
    if (dist_valid) begin
      if (raw_up > level_reg) begin
        level_next = raw_up;
      end else if (raw_dn < level_reg) begin
        level_next = raw_dn;
      end
    end
  end

`ifdef LED_PEAK_HOLD_EN
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [LW-1:0] peak_reg;
  logic [TW-1:0] timer_reg;
  logic [TW-1:0] timer_next;

  always_comb begin
    peak_next  = peak_reg;
    timer_next = timer_reg;
    if (level_next > peak_reg) begin
      peak_next  = level_next;
      timer_next = TW'(HOLD_CYCLES - 1);
    end else if (peak_reg > level_next) begin
      if (timer_reg == '0) begin
        // peak_reg > level_next, so a single step never drops below the level.
        peak_next  = peak_reg - 1'b1;
        timer_next = TW'(HOLD_CYCLES - 1);
      end else begin
        timer_next = timer_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_reg  <= '0;
      timer_reg <= '0;
    end else begin
      peak_reg  <= peak_next;
      timer_reg <= timer_next;
    end
  end

  assign peak_level = peak_reg;
`else
  assign peak_next  = level_next;
  assign peak_level = level_reg;
`endif

  // Bar mode lights bits below the level. Dot mode lights only bit level-1.
  // The peak marker is ORed in when the feature is enabled.
  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      logic bar_bit;
      logic dot_bit;
      logic peak_bit;
      assign bar_bit = (LW'(gi) < level_next);
      assign dot_bit = (level_next == LW'(gi + 1));
`ifdef LED_PEAK_HOLD_EN
      assign peak_bit = (peak_next == LW'(gi + 1));
`else
      assign peak_bit = 1'b0;
`endif
      assign led_next[gi] = (mode ? dot_bit : bar_bit) | peak_bit;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      level_reg <= '0;
      led_reg   <= '0;
    end else begin
      level_reg <= level_next;
      led_reg   <= led_next;
    end
  end

  assign level = level_reg;
  assign LED   = led_reg;

endmodule

// File: tb/tb_led_bargraph_ctrl.sv
module tb_led_bargraph_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [25:0] dist_counter = '0;
  logic        dist_valid = 1'b0;
  logic        mode = 1'b0;
  logic [9:0]  LED;
  logic [3:0]  level;
  logic [3:0]  peak_level;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [9:0] led;
    logic [3:0] lvl;
  } exp_t;

  exp_t q[$];
  exp_t e;

  led_bargraph_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .dist_counter (dist_counter),
    .dist_valid   (dist_valid),
    .mode         (mode),
    .LED          (LED),
    .level        (level),
    .peak_level   (peak_level)
  );

  always #5 clk = ~clk;

  // Drive inputs for one cycle. Then queue what the outputs must show after that edge.
  // Inputs change 1 time unit after posedge, away from the sampling edge.
  task automatic apply(input string name, input logic r, input logic v,
                       input logic [25:0] d, input logic m,
                       input logic [9:0] exp_led, input logic [3:0] exp_lvl);
    exp_t x;
    reset        = r;
    dist_valid   = v;
    dist_counter = d;
    mode         = m;
    @(posedge clk);
    x.name = name;
    x.led  = exp_led;
    x.lvl  = exp_lvl;
    q.push_back(x);
    #1;
  endtask

  // Monitor: outputs are stable at negedge, pop and compare one transaction per cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (LED !== e.led || level !== e.lvl || peak_level !== e.lvl) begin
        errors++;
        $display("FAIL %s: got LED=%h level=%0d peak=%0d, expected LED=%h level=%0d peak=%0d",
                 e.name, LED, level, peak_level, e.led, e.lvl, e.lvl);
      end else begin
        $display("ok   %s: LED=%h level=%0d peak=%0d", e.name, LED, level, peak_level);
      end
    end
  end

  initial begin
    #1;
    // 1: reset with a full-scale valid sample must keep everything cleared.
    for (int i = 0; i < 3; i++)
      apply("reset_hold", 1'b1, 1'b1, 26'd145000, 1'b0, 10'h000, 4'd0);

    // 2: bar mode, exact threshold and hysteresis band.
    apply("bar_43500",  1'b0, 1'b1, 26'd43500, 1'b0, 10'h007, 4'd3);
    apply("bar_43499",  1'b0, 1'b1, 26'd43499, 1'b0, 10'h007, 4'd3);
    apply("bar_42999",  1'b0, 1'b1, 26'd42999, 1'b0, 10'h003, 4'd2);

    // 3: dot mode, drop to zero, then a mode change alone.
    apply("dot_72500",  1'b0, 1'b1, 26'd72500, 1'b1, 10'h010, 4'd5);
    apply("dot_zero",   1'b0, 1'b1, 26'd0,     1'b1, 10'h000, 4'd0);
    apply("dot_72500b", 1'b0, 1'b1, 26'd72500, 1'b1, 10'h010, 4'd5);
    apply("mode_to_bar",1'b0, 1'b0, 26'd0,     1'b0, 10'h01F, 4'd5);

    // 4: saturation and the top-level hysteresis band.
    apply("sat_ones",   1'b0, 1'b1, 26'h3FFFFFF, 1'b0, 10'h3FF, 4'd10);
    apply("sat_dot",    1'b0, 1'b0, 26'h3FFFFFF, 1'b1, 10'h200, 4'd10);
    apply("top_145000", 1'b0, 1'b1, 26'd145000,  1'b0, 10'h3FF, 4'd10);
    apply("top_144999", 1'b0, 1'b1, 26'd144999,  1'b0, 10'h3FF, 4'd10);
    apply("top_144499", 1'b0, 1'b1, 26'd144499,  1'b0, 10'h1FF, 4'd9);

    // 6: no valid for 100 cycles while dist wanders.
    for (int i = 0; i < 100; i++)
      apply("no_valid", 1'b0, 1'b0, 26'(i * 1700), 1'b0, 10'h1FF, 4'd9);

    // A rising jump from a low level, then reset together with a valid sample.
    apply("jump_zero",  1'b0, 1'b1, 26'd0,      1'b0, 10'h000, 4'd0);
    apply("jump_116000",1'b0, 1'b1, 26'd116000, 1'b0, 10'h0FF, 4'd8);
    apply("reset_wins", 1'b1, 1'b1, 26'h3FFFFFF, 1'b0, 10'h000, 4'd0);
    apply("after_reset",1'b0, 1'b0, 26'h3FFFFFF, 1'b0, 10'h000, 4'd0);

    // Let the monitor drain, with a bound.
    for (int i = 0; i < 5 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d transactions left unchecked, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
